regfile_sb: RTL

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 90 +++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// Register file with per-register write-pending scoreboard and operand stall.
// Optional same-cycle write-through bypass when REGFILE_SB_BYPASS_EN is defined.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRP  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic [NRP*AW-1:0]   raddr,
  input  logic [NRP-1:0]      ruse,
  output logic [NRP*XLEN-1:0] rdata,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  input  logic                flush,
  output logic [NREG-1:0]     busy,
  output logic                stall,
  output logic [AW:0]         pend_cnt
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_nxt;
  logic [AW:0]     pend_q;

  function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) c = c + (AW+1)'(v[i]);
    return c;
  endfunction

  // Scoreboard next state: clear on write-back, set on issue (set wins), flush clears all.
  always_comb begin
    busy_nxt = busy_q;
    if (we && waddr != '0) busy_nxt[waddr] = 1'b0;
    if (iss_valid && iss_rd != '0) busy_nxt[iss_rd] = 1'b1;
    if (flush) busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      pend_q <= '0;
    end else begin
      busy_q <= busy_nxt;
      pend_q <= popcount(busy_nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  // Combinational read ports; register 0 is hard-wired to zero.
  always_comb begin
    logic [AW-1:0] ra;
    logic          hit;
    rdata = '0;
    stall = 1'b0;
    ra    = '0;
    hit   = 1'b0;
    for (int p = 0; p < NRP; p++) begin
      ra = raddr[p*AW +: AW];
`ifdef REGFILE_SB_BYPASS_EN
      hit = we && (waddr == ra);
`else
      hit = 1'b0;
`endif
      if (ra != '0) begin
        // Bypass is held off during reset so reads stay zero while rst is high.
        rdata[p*XLEN +: XLEN] = (hit && !rst) ? wdata : regs[ra];
        if (ruse[p] && busy_q[ra] && !hit) stall = 1'b1;
      end
    end
  end

  assign busy     = busy_q;
  assign pend_cnt = pend_q;

endmodule
